id_ex_stage_reg: RTL

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

---
 rtl/id_ex_stage_reg.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
// ---------------
// ID/EX pipeline register with built-in hazard detection.
//
// Each rising edge copies the decoded instruction from the ID stage into the
// EX stage. When the instruction in ID depends on a result that is not yet
// available, the register inserts a bubble and raises hazard_stall so that
// the PC and IF/ID register hold for that cycle.
//
// A result is not yet available in two cases:
//   - A load is in EX. Its data only exists after MEM, so one bubble is
//     needed even with forwarding.
//   - Forwarding is disabled and any register writer is in EX or MEM.
//
// Register 0 never causes a hazard.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   freeze              memory-stage stall; the whole register holds
//   flush               branch taken in EX; the ID instruction is killed
//   forwarding_enable   forwarding unit active (only load-use stalls)
//   id_*                ID-stage instruction fields and control bits
//   mem_dest, mem_wb_en register writer currently in the MEM stage
//   ex_*                registered copies of the id_* fields
//   hazard_stall        combinational; hold PC and IF/ID this cycle
//   bubble_count        saturating count of inserted bubbles
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              forwarding_enable,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_val1,
  input  logic [DATA_W-1:0] id_val2,
  input  logic [DATA_W-1:0] id_val3,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_src1,
  input  logic [4:0]        id_src2,
  input  logic [4:0]        id_src3,
  input  logic [4:0]        id_dest,
  input  logic              id_uses_src2,
  input  logic              id_store_bne,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              id_mem_w_en,
  input  logic              id_branch,
  input  logic              id_is_imm,
  input  logic [CMD_W-1:0]  id_exe_cmd,
  input  logic [4:0]        mem_dest,
  input  logic              mem_wb_en,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [DATA_W-1:0] ex_val3,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_src1,
  output logic [4:0]        ex_src2,
  output logic [4:0]        ex_src3,
  output logic [4:0]        ex_dest,
  output logic              ex_uses_src2,
  output logic              ex_store_bne,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic              ex_branch,
  output logic              ex_is_imm,
  output logic [CMD_W-1:0]  ex_exe_cmd,
  output logic              hazard_stall,
  output logic [15:0]       bubble_count
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] val1_q, val1_d;
  logic [DATA_W-1:0] val2_q, val2_d;
  logic [DATA_W-1:0] val3_q, val3_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        src1_q, src1_d;
  logic [4:0]        src2_q, src2_d;
  logic [4:0]        src3_q, src3_d;
  logic [4:0]        dest_q, dest_d;
  logic              uses_src2_q, uses_src2_d;
  logic              store_bne_q, store_bne_d;
  logic              wb_en_q, wb_en_d;
  logic              mem_r_en_q, mem_r_en_d;
  logic              mem_w_en_q, mem_w_en_d;
  logic              branch_q, branch_d;
  logic              is_imm_q, is_imm_d;
  logic [CMD_W-1:0]  exe_cmd_q, exe_cmd_d;
  logic [15:0]       bubble_count_q, bubble_count_d;

  logic ex_match;
  logic mem_match;
  logic load_use_haz;
  logic ex_alu_haz;
  logic mem_haz;
  logic hazard;

  // A source operand matches a writer only when the instruction actually
  // reads that operand. src2 is read only for register-form operands, and
  // src3 is read only by stores and bne.
  always_comb begin
    ex_match  = (id_src1 == dest_q)
              | (id_uses_src2 & (id_src2 == dest_q))
              | (id_store_bne & (id_src3 == dest_q));
    mem_match = (id_src1 == mem_dest)
              | (id_uses_src2 & (id_src2 == mem_dest))
              | (id_store_bne & (id_src3 == mem_dest));

    load_use_haz = valid_q & mem_r_en_q & (dest_q != 5'd0) & id_valid & ex_match;
    ex_alu_haz   = ~forwarding_enable & valid_q & wb_en_q & (dest_q != 5'd0)
                 & id_valid & ex_match;
    mem_haz      = ~forwarding_enable & mem_wb_en & (mem_dest != 5'd0)
                 & id_valid & mem_match;
    hazard       = load_use_haz | ex_alu_haz | mem_haz;
  end

  // A flushed ID instruction is discarded, so there is no reason to hold the
  // front end for it.
  assign hazard_stall = hazard & ~flush & ~rst;

  // Default is to hold, which covers freeze. Flushes and bubbles still load
  // the datapath fields; only valid and the side-effecting control bits
  // need to be cleared.
  always_comb begin
    valid_d        = valid_q;
    pc_d           = pc_q;
    val1_d         = val1_q;
    val2_d         = val2_q;
    val3_d         = val3_q;
    imm_d          = imm_q;
    src1_d         = src1_q;
    src2_d         = src2_q;
    src3_d         = src3_q;
    dest_d         = dest_q;
    uses_src2_d    = uses_src2_q;
    store_bne_d    = store_bne_q;
    wb_en_d        = wb_en_q;
    mem_r_en_d     = mem_r_en_q;
    mem_w_en_d     = mem_w_en_q;
    branch_d       = branch_q;
    is_imm_d       = is_imm_q;
    exe_cmd_d      = exe_cmd_q;
    bubble_count_d = bubble_count_q;

    if (!freeze) begin
      pc_d        = id_pc;
      val1_d      = id_val1;
      val2_d      = id_val2;
      val3_d      = id_val3;
      imm_d       = id_imm;
      src1_d      = id_src1;
      src2_d      = id_src2;
      src3_d      = id_src3;
      dest_d      = id_dest;
      uses_src2_d = id_uses_src2;
      store_bne_d = id_store_bne;
      is_imm_d    = id_is_imm;
      exe_cmd_d   = id_exe_cmd;

      if (flush || hazard) begin
        valid_d    = 1'b0;
        wb_en_d    = 1'b0;
        mem_r_en_d = 1'b0;
        mem_w_en_d = 1'b0;
        branch_d   = 1'b0;
      end else begin
        valid_d    = id_valid;
        wb_en_d    = id_wb_en & id_valid;
        mem_r_en_d = id_mem_r_en & id_valid;
        mem_w_en_d = id_mem_w_en & id_valid;
        branch_d   = id_branch & id_valid;
      end

      // Only a real bubble is counted; a flush that coincides with a
      // hazard is not.
      if (!flush && hazard && (bubble_count_q != 16'hFFFF)) begin
        bubble_count_d = bubble_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= 1'b0;
      pc_q           <= '0;
      val1_q         <= '0;
      val2_q         <= '0;
      val3_q         <= '0;
      imm_q          <= '0;
      src1_q         <= 5'd0;
      src2_q         <= 5'd0;
      src3_q         <= 5'd0;
      dest_q         <= 5'd0;
      uses_src2_q    <= 1'b0;
      store_bne_q    <= 1'b0;
      wb_en_q        <= 1'b0;
      mem_r_en_q     <= 1'b0;
      mem_w_en_q     <= 1'b0;
      branch_q       <= 1'b0;
      is_imm_q       <= 1'b0;
      exe_cmd_q      <= '0;
      bubble_count_q <= 16'd0;
    end else begin
      valid_q        <= valid_d;
      pc_q           <= pc_d;
      val1_q         <= val1_d;
      val2_q         <= val2_d;
      val3_q         <= val3_d;
      imm_q          <= imm_d;
      src1_q         <= src1_d;
      src2_q         <= src2_d;
      src3_q         <= src3_d;
      dest_q         <= dest_d;
      uses_src2_q    <= uses_src2_d;
      store_bne_q    <= store_bne_d;
      wb_en_q        <= wb_en_d;
      mem_r_en_q     <= mem_r_en_d;
      mem_w_en_q     <= mem_w_en_d;
      branch_q       <= branch_d;
      is_imm_q       <= is_imm_d;
      exe_cmd_q      <= exe_cmd_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_val1      = val1_q;
  assign ex_val2      = val2_q;
  assign ex_val3      = val3_q;
  assign ex_imm       = imm_q;
  assign ex_src1      = src1_q;
  assign ex_src2      = src2_q;
  assign ex_src3      = src3_q;
  assign ex_dest      = dest_q;
  assign ex_uses_src2 = uses_src2_q;
  assign ex_store_bne = store_bne_q;
  assign ex_wb_en     = wb_en_q;
  assign ex_mem_r_en  = mem_r_en_q;
  assign ex_mem_w_en  = mem_w_en_q;
  assign ex_branch    = branch_q;
  assign ex_is_imm    = is_imm_q;
  assign ex_exe_cmd   = exe_cmd_q;
  assign bubble_count = bubble_count_q;

endmodule
